// File: rtl/rv32i_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states,
// byte-enable patterns, funct3 encodings and the alignment/legality checks.
package rv32i_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  function automatic logic funct3_illegal(input logic [2:0] func3);
    return (func3 == 3'b011) || (func3[2:1] == 2'b11);
  endfunction

  // Access size comes from func3[1:0] for loads and stores alike.
  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or
// zero-extends it according to the load funct3.
module rv32i_load_align
  import rv32i_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rdata,
  input  logic [1:0]       i_addr_lo,
  input  logic [2:0]       i_func3,
  output logic [WIDTH-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_result = i_rdata;
    case (i_func3)
      FUNCT3_LB:  o_result = {{(WIDTH-8){w_byte[7]}}, w_byte};
      FUNCT3_LBU: o_result = {{(WIDTH-8){1'b0}}, w_byte};
      FUNCT3_LH:  o_result = {{(WIDTH-16){w_half[15]}}, w_half};
      FUNCT3_LHU: o_result = {{(WIDTH-16){1'b0}}, w_half};
      default:    o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: formats store requests, waits on the memory
// ready handshake, and returns aligned load data while stalling the pipe.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_lsu_valid,
  input  logic                  i_lsu_we,
  input  logic                  i_lsu_re,
  input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
  input  logic [WIDTH-1:0]      i_lsu_wdata,
  input  logic [2:0]            i_lsu_func3,
  output logic                  o_lsu_stall,
  output logic                  o_lsu_done,
  output logic [WIDTH-1:0]      o_lsu_rdata,
  output logic                  o_lsu_fault,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [WIDTH-1:0]      o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [WIDTH-1:0]      i_mem_rdata
);

  lsu_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_addr_lo;
  logic [2:0]            r_func3;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rdata;

  logic                  w_fault;
  logic [3:0]            w_be;
  logic [WIDTH-1:0]      w_wdata;
  logic [WIDTH-1:0]      w_load_result;

  assign w_fault = funct3_illegal(i_lsu_func3) | misaligned(i_lsu_func3, i_lsu_addr[1:0]);

  // Stores replicate the data across lanes so the memory only needs byte enables.
  always_comb begin
    w_be    = BE_WORD;
    w_wdata = i_lsu_wdata;
    if (i_lsu_we) begin
      case (i_lsu_func3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_lsu_addr[1:0];
          w_wdata = {(WIDTH/8){i_lsu_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = i_lsu_addr[1] ? BE_HI_HALF : BE_LO_HALF;
          w_wdata = {(WIDTH/16){i_lsu_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  rv32i_load_align #(.WIDTH(WIDTH)) u_load_align (
    .i_rdata   (i_mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_func3   (r_func3),
    .o_result  (w_load_result)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_addr_lo <= '0;
      r_func3   <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_lsu_valid) begin
            r_addr    <= {i_lsu_addr[ADDR_WIDTH-1:2], 2'b00};
            r_addr_lo <= i_lsu_addr[1:0];
            r_func3   <= i_lsu_func3;
            r_we      <= i_lsu_we;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            if (w_fault)                     r_state <= ST_ERR;
            else if (!i_lsu_we && !i_lsu_re) r_state <= ST_DONE;
            else                             r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) r_state <= r_we ? ST_DONE : ST_RESP;
        end
        ST_RESP: begin
          r_rdata <= w_load_result;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_req   = (r_state == ST_REQ);
  assign o_mem_we    = o_mem_req & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_be    = r_be;
  assign o_mem_wdata = r_wdata;
  assign o_lsu_done  = (r_state == ST_DONE);
  assign o_lsu_fault = (r_state == ST_ERR);
  assign o_lsu_rdata = r_rdata;
  assign o_lsu_stall = ((r_state == ST_IDLE) & i_lsu_valid) | (r_state == ST_REQ) | (r_state == ST_RESP);

endmodule

// File: tb/tb_rv32i_lsu.sv
// Randomized self-checking bench for rv32i_lsu: a byte-addressed reference
// memory predicts bus fields, latencies and load results for every op.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_lsu_valid, i_lsu_we, i_lsu_re;
  logic [31:0] i_lsu_addr, i_lsu_wdata;
  logic [2:0]  i_lsu_func3;
  logic        o_lsu_stall, o_lsu_done, o_lsu_fault;
  logic [31:0] o_lsu_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] bus_mem   [64];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  rv32i_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .i_lsu_valid (i_lsu_valid),
    .i_lsu_we    (i_lsu_we),
    .i_lsu_re    (i_lsu_re),
    .i_lsu_addr  (i_lsu_addr),
    .i_lsu_wdata (i_lsu_wdata),
    .i_lsu_func3 (i_lsu_func3),
    .o_lsu_stall (o_lsu_stall),
    .o_lsu_done  (o_lsu_done),
    .o_lsu_rdata (o_lsu_rdata),
    .o_lsu_fault (o_lsu_fault),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata)
  );

  task automatic set_word(input logic [7:0] addr, input logic [31:0] value);
    bus_mem[addr[7:2]] = value;
    for (int i = 0; i < 4; i++) model_mem[{addr[7:2], 2'b00} + i] = value[8*i +: 8];
  endtask

  // Drives one op from IDLE, plays the memory side, then compares every observable.
  task automatic run_op(input string name, input logic we, input logic re, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input int waits);
    int          size, end_cyc, exp_done, exp_fault_cyc, done_cyc, fault_cyc;
    int          done_n, fault_n, req_n;
    logic        exp_fault, exp_req, stable, stall_ok, pending, req_ever;
    logic [3:0]  exp_be, f_be;
    logic [31:0] exp_wdata, exp_rd, f_addr, f_wdata;
    logic        f_we;
    logic [7:0]  pend_idx;
    size      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (int'(addr) % size != 0);
    exp_req   = !exp_fault && (we || re);
    exp_done  = exp_fault ? -1 : (!we && !re) ? 1 : we ? 2 + waits : 3 + waits;
    exp_fault_cyc = exp_fault ? 1 : -1;
    end_cyc   = exp_fault ? 1 : exp_done;
    exp_be    = 4'hF;
    exp_wdata = wdata;
    if (we) begin
      exp_be = 4'h0;
      for (int b = 0; b < 4; b++)
        if (b >= int'(addr) % 4 && b < int'(addr) % 4 + size) exp_be[b] = 1'b1;
      if (size == 1) exp_wdata = {24'h0, wdata[7:0]} * 32'h01010101;
      if (size == 2) exp_wdata = {16'h0, wdata[15:0]} * 32'h00010001;
    end
    exp_rd = model_rdata;
    if (exp_req && we) begin
      for (int i = 0; i < size; i++) model_mem[addr + 8'(i)] = wdata[8*i +: 8];
    end else if (exp_req) begin
      exp_rd = 32'h0;
      for (int i = 0; i < size; i++) exp_rd = exp_rd | ({24'h0, model_mem[addr + 8'(i)]} << (8 * i));
      if (!f3[2] && size == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFFFF00;
      if (!f3[2] && size == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
    end

    done_cyc = -1; fault_cyc = -1; done_n = 0; fault_n = 0; req_n = 0;
    stable = 1'b1; stall_ok = 1'b1; pending = 1'b0; req_ever = 1'b0;
    f_addr = '0; f_be = '0; f_wdata = '0; f_we = 1'b0; pend_idx = '0;
    @(negedge clk);
    i_lsu_valid = 1'b1; i_lsu_we = we; i_lsu_re = re;
    i_lsu_addr = {24'h0, addr}; i_lsu_wdata = wdata; i_lsu_func3 = f3;
    i_mem_ready = (waits == 0);
    for (int cyc = 0; cyc < waits + 8; cyc++) begin
      #1;
      if (o_lsu_stall !== (cyc < end_cyc)) stall_ok = 1'b0;
      if (o_lsu_done === 1'b1)  begin done_n++;  if (done_cyc < 0)  done_cyc = cyc;  end
      if (o_lsu_fault === 1'b1) begin fault_n++; if (fault_cyc < 0) fault_cyc = cyc; end
      if (o_mem_req === 1'b1) begin
        if (!req_ever) begin
          f_addr = o_mem_addr; f_be = o_mem_be; f_wdata = o_mem_wdata; f_we = o_mem_we;
        end else if (o_mem_addr !== f_addr || o_mem_be !== f_be || o_mem_wdata !== f_wdata || o_mem_we !== f_we) begin
          stable = 1'b0;
        end
        req_ever = 1'b1;
        req_n++;
        if (i_mem_ready) begin
          if (o_mem_we) begin
            for (int b = 0; b < 4; b++)
              if (o_mem_be[b]) bus_mem[o_mem_addr[7:2]][8*b +: 8] = o_mem_wdata[8*b +: 8];
          end else begin
            pending = 1'b1; pend_idx = o_mem_addr[7:0];
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      i_lsu_valid = 1'b0;
      i_mem_rdata = pending ? bus_mem[pend_idx[7:2]] : $urandom;
      pending     = 1'b0;
      i_mem_ready = (req_n >= waits);
    end

    total++; if (done_cyc !== exp_done) begin bad++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done); end
    total++; if (fault_cyc !== exp_fault_cyc) begin bad++; $display("FAIL %s fault_cycle: got %0d want %0d", name, fault_cyc, exp_fault_cyc); end
    total++; if (done_n + fault_n !== 1) begin bad++; $display("FAIL %s pulse_count: got %0d want 1", name, done_n + fault_n); end
    total++; if (req_ever !== exp_req) begin bad++; $display("FAIL %s mem_req_seen: got %0b want %0b", name, req_ever, exp_req); end
    if (exp_req) begin
      total++; if (f_addr !== {24'h0, addr[7:2], 2'b00}) begin bad++; $display("FAIL %s mem_addr: got %h want %h", name, f_addr, {24'h0, addr[7:2], 2'b00}); end
      total++; if (f_be !== exp_be) begin bad++; $display("FAIL %s mem_be: got %b want %b", name, f_be, exp_be); end
      total++; if (f_we !== we) begin bad++; $display("FAIL %s mem_we: got %b want %b", name, f_we, we); end
      total++; if (req_n !== waits + 1) begin bad++; $display("FAIL %s req_cycles: got %0d want %0d", name, req_n, waits + 1); end
      total++; if (!stable) begin bad++; $display("FAIL %s req_stable: got unstable want stable", name); end
      if (we) begin
        total++; if (f_wdata !== exp_wdata) begin bad++; $display("FAIL %s mem_wdata: got %h want %h", name, f_wdata, exp_wdata); end
      end
    end
    total++; if (!stall_ok) begin bad++; $display("FAIL %s stall_profile: got wrong want high for cycles 0..%0d", name, end_cyc - 1); end
    model_rdata = exp_rd;
    total++; if (o_lsu_rdata !== model_rdata) begin bad++; $display("FAIL %s lsu_rdata: got %h want %h", name, o_lsu_rdata, model_rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_re = 1'b0;
    i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_func3 = '0; i_mem_ready = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({o_lsu_stall, o_lsu_done, o_lsu_fault, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_lsu_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b done=%b fault=%b req=%b we=%b be=%b addr=%h wd=%h rd=%h want all zero",
               o_lsu_stall, o_lsu_done, o_lsu_fault, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_lsu_rdata);
    end
    model_rdata = 32'h0;
  endtask

  task automatic test_store();
    run_op("sw_0x0", 1'b1, 1'b0, 8'h00, 32'hDEADBEEF, 3'b010, 0);
    run_op("sb_0x9", 1'b1, 1'b0, 8'h09, 32'hDEADBEEF, 3'b000, 0);
    run_op("sh_0x6", 1'b1, 1'b0, 8'h06, 32'hDEADBEEF, 3'b001, 0);
    run_op("we_re_both", 1'b1, 1'b1, 8'h20, 32'h0BADF00D, 3'b010, 0);
  endtask

  task automatic test_load();
    set_word(8'h0C, 32'hFFFB1234);
    run_op("lh_0xE",  1'b0, 1'b1, 8'h0E, 32'h0, 3'b001, 0);
    run_op("lhu_0xE", 1'b0, 1'b1, 8'h0E, 32'h0, 3'b101, 0);
    set_word(8'h0C, 32'h12348056);
    run_op("lb_0xD",  1'b0, 1'b1, 8'h0D, 32'h0, 3'b000, 0);
    run_op("lbu_0xD", 1'b0, 1'b1, 8'h0D, 32'h0, 3'b100, 0);
    run_op("lw_0xC",  1'b0, 1'b1, 8'h0C, 32'h0, 3'b010, 0);
  endtask

  task automatic test_fault();
    run_op("lw_misaligned", 1'b0, 1'b1, 8'h06, 32'h0, 3'b010, 0);
    run_op("f3_111",        1'b0, 1'b1, 8'h00, 32'h0, 3'b111, 0);
    run_op("lh_odd",        1'b0, 1'b1, 8'h03, 32'h0, 3'b001, 0);
    run_op("sw_misaligned", 1'b1, 1'b0, 8'h12, 32'h12345678, 3'b010, 0);
    run_op("no_op",         1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 0);
  endtask

  task automatic test_wait_states();
    run_op("sw_wait3", 1'b1, 1'b0, 8'h10, 32'hCAFEF00D, 3'b010, 3);
    run_op("lw_wait2", 1'b0, 1'b1, 8'h10, 32'h0, 3'b010, 2);
    run_op("lb_wait1", 1'b0, 1'b1, 8'h13, 32'h0, 3'b000, 1);
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    @(negedge clk);
    i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_lsu_re = 1'b0;
    i_lsu_addr = 32'h10; i_lsu_wdata = 32'h55AA55AA; i_lsu_func3 = 3'b010; i_mem_ready = 1'b0;
    @(negedge clk);
    i_lsu_valid = 1'b0;
    #1;
    total++; if (o_mem_req !== 1'b1) begin bad++; $display("FAIL mid_reset_req_before: got %b want 1", o_mem_req); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (o_mem_req !== 1'b0 || o_lsu_stall !== 1'b0) begin bad++; $display("FAIL mid_reset_idle: got req=%b stall=%b want 0 0", o_mem_req, o_lsu_stall); end
    model_rdata = 32'h0;
    pulses = 0;
    i_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (o_lsu_done || o_lsu_fault || o_mem_req) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", pulses); end
    run_op("lw_after_reset", 1'b0, 1'b1, 8'h00, 32'h0, 3'b010, 0);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic        we, re;
    int          kind;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 19);
      addr = 8'($urandom_range(0, 255));
      we = 1'b0; re = 1'b0;
      if (kind < 8) begin
        we = 1'b1; re = ($urandom_range(0, 5) == 0);
        f3 = 3'($urandom_range(0, 2));
      end else if (kind < 17) begin
        re = 1'b1;
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else if (kind < 19) begin
        re = 1'b1;
        case ($urandom_range(0, 2)) 0: f3 = 3'b011; 1: f3 = 3'b110; default: f3 = 3'b111; endcase
      end else begin
        f3 = 3'b010; addr = 8'h00;
      end
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      run_op("random", we, re, addr, $urandom, f3, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);
    model_rdata = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_wait_states();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
